// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing and a one-cycle done pulse.
// Optional periodic reload when COUNTDOWN_AUTO_RELOAD_EN is defined.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;
`endif

  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN) || (state == DONE);
  assign done       = (state == DONE);
  assign zero       = (count == '0);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_nxt = reload;
`endif
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          count_nxt = load_value;
          state_nxt = (load_value != '0) ? RUN : DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (load_value != '0)
            reload_nxt = load_value;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (enable) begin
          // count is never 0 in RUN; the guard keeps wrap unreachable
          if (count <= WIDTH'(1)) begin
            state_nxt = DONE;
            count_nxt = '0;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (reload != '0) begin
            state_nxt = RUN;
            count_nxt = reload;
          end else begin
            state_nxt = IDLE;
            count_nxt = '0;
          end
`else
          state_nxt = IDLE;
          count_nxt = '0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      reload <= '0;
    else
      reload <= reload_nxt;
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         zero;
  logic         done;

  int tests = 0;
  int fails = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .enable    (enable),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .zero      (zero),
    .done      (done)
  );

  always #5 clk = ~clk;

  // packed view: {count, busy, done, load_ready, zero}
  function automatic logic [W+3:0] pk(input int c, input bit b,
                                      input bit d, input bit r);
    pk = {W'(c), b, d, r, (c == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0;
    load_value = '0;
    enable     = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({count, busy, done, load_ready, zero} !== pk(0, 0, 0, 1)) begin
      fails++;
      $display("FAIL reset: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(0, 0, 0, 1));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_zero();
    load_valid = 1'b1;
    load_value = '0;
    tick();
    load_valid = 1'b0;
    tests++;
    if ({count, busy, done, load_ready, zero} !== pk(0, 1, 1, 0)) begin
      fails++;
      $display("FAIL load_zero_done: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(0, 1, 1, 0));
    end
    tick();
    tests++;
    if ({count, busy, done, load_ready, zero} !== pk(0, 0, 0, 1)) begin
      fails++;
      $display("FAIL load_zero_idle: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(0, 0, 0, 1));
    end
  endtask

  task automatic test_load3();
    int exp_c[4] = '{3, 2, 1, 0};
    load_valid = 1'b1;
    load_value = 8'd3;
    enable     = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({count, busy, done, load_ready, zero} !==
          pk(exp_c[i], 1, (i == 3), 0)) begin
        fails++;
        $display("FAIL load3[%0d]: got %h want %h", i,
                 {count, busy, done, load_ready, zero},
                 pk(exp_c[i], 1, (i == 3), 0));
      end
      if (i < 3) tick();
    end
    tick();
    tests++;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    if ({count, busy, done, load_ready, zero} !== pk(3, 1, 0, 0)) begin
      fails++;
      $display("FAIL load3_after: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(3, 1, 0, 0));
    end
`else
    if ({count, busy, done, load_ready, zero} !== pk(0, 0, 0, 1)) begin
      fails++;
      $display("FAIL load3_after: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(0, 0, 0, 1));
    end
`endif
    idle_inputs();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_enable_toggle();
    int exp_c[5] = '{5, 4, 4, 3, 3};
    bit en_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    load_valid = 1'b1;
    load_value = 8'd5;
    enable     = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({count, busy, done, load_ready, zero} !== pk(exp_c[i], 1, 0, 0)) begin
        fails++;
        $display("FAIL en_toggle[%0d]: got %h want %h", i,
                 {count, busy, done, load_ready, zero}, pk(exp_c[i], 1, 0, 0));
      end
      if (i < 4) begin
        enable = en_seq[i];
        tick();
      end
    end
    idle_inputs();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    load_valid = 1'b1;
    load_value = 8'd4;
    enable     = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (count !== 8'd2) begin
      fails++;
      $display("FAIL abort_pre: got %0d want 2", count);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({count, busy, done, load_ready, zero} !== pk(0, 0, 0, 1)) begin
      fails++;
      $display("FAIL abort_idle: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(0, 0, 0, 1));
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL abort_nodone: got %b want 0", done);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    load_valid = 1'b1;
    load_value = 8'd8;
    enable     = 1'b1;
    tick();
    load_value = 8'd200;
    tick();
    tick();
    tests++;
    if ({count, busy, load_ready} !== {8'd6, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL async_pre: got count=%0d busy=%b ready=%b want 6 1 0",
               count, busy, load_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({count, busy, done, load_ready, zero} !== pk(0, 0, 0, 1)) begin
      fails++;
      $display("FAIL async_reset: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(0, 0, 0, 1));
    end
    load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_valid = 1'b1;
    load_value = 8'd7;
    enable     = 1'b0;
    tick();
    load_valid = 1'b0;
    tests++;
    if ({count, busy, done, load_ready, zero} !== pk(7, 1, 0, 0)) begin
      fails++;
      $display("FAIL first_load: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(7, 1, 0, 0));
    end
    idle_inputs();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    load_valid = 1'b1;
    load_value = 8'd2;
    enable     = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tests++;
      if ({count, busy, done, load_ready, zero} !==
          pk(2 - (i % 3), 1, (i % 3 == 2), 0)) begin
        fails++;
        $display("FAIL auto_reload[%0d]: got %h want %h", i,
                 {count, busy, done, load_ready, zero},
                 pk(2 - (i % 3), 1, (i % 3 == 2), 0));
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({count, busy, done, load_ready, zero} !== pk(0, 0, 0, 1)) begin
      fails++;
      $display("FAIL auto_abort: got %h want %h",
               {count, busy, done, load_ready, zero}, pk(0, 0, 0, 1));
    end
    idle_inputs();
  endtask
`endif

  // Reference: m_idle/m_cnt/m_done/m_rl tracked from the stated rules.
  task automatic test_random();
    bit m_idle = 1'b1;
    bit m_done = 1'b0;
    int m_cnt  = 0;
    int m_rl   = 0;
    int nerr   = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      load_value = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255))
                                               : W'($urandom_range(0, 6));
      enable     = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 19) == 0);
      if (m_idle) begin
        if (load_valid) begin
          m_cnt  = int'(load_value);
          m_idle = 1'b0;
          m_done = (m_cnt == 0);
          if (m_cnt != 0) m_rl = m_cnt;
        end
      end else if (abort) begin
        m_idle = 1'b1;
        m_done = 1'b0;
        m_cnt  = 0;
      end else if (m_done) begin
        m_done = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (m_rl != 0) m_cnt = m_rl;
        else m_idle = 1'b1;
`else
        m_idle = 1'b1;
`endif
      end else if (enable) begin
        m_cnt  = m_cnt - 1;
        m_done = (m_cnt == 0);
      end
      tick();
      tests++;
      if ({count, busy, done, load_ready, zero} !==
          pk(m_cnt, !m_idle, m_done, m_idle)) begin
        fails++;
        nerr++;
        if (nerr <= 10)
          $display("FAIL random[%0d]: got %h want %h", n,
                   {count, busy, done, load_ready, zero},
                   pk(m_cnt, !m_idle, m_done, m_idle));
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_load_zero();
    test_load3();
    test_enable_toggle();
    test_abort();
    test_async_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
